// File: rtl/teclado_pkg.sv
`default_nettype none
// ============================================================================
// Module : teclado_pkg
// Purpose: Shared types and helpers for the teclado_scan keypad scanner.
//          - scan FSM state encoding
//          - frame-result kind encoding
//          - constant-foldable ceil(log2) helper
// Ports  : none (package)
// Rev    : 1.0 - initial parametrised release
// ============================================================================
package teclado_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_EVAL  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_KEY  = 2'd1,
    RES_MULT = 2'd2
  } res_e;

  // ceil(log2(v)); returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/teclado_sync.sv
`default_nettype none
// ============================================================================
// Module : teclado_sync
// Purpose: W-bit two-flop synchroniser for the asynchronous row lines.
//          Resets to all ones (the idle level of the active-low rows).
// Ports  : clk      - clock
//          rst_n    - asynchronous active-low reset
//          async_i  - asynchronous input bus
//          sync_o   - synchronised output bus (2-cycle latency)
// Rev    : 1.0 - initial parametrised release
// ============================================================================
module teclado_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/teclado_scan.sv
`default_nettype none
// ============================================================================
// Module : teclado_scan
// Purpose: Matrix keypad scanner. Drives one column low at a time, samples the
//          synchronised active-low rows, debounces whole-frame results and
//          emits registered press / release / auto-repeat events.
// Ports  : clk          - clock (posedge)
//          rst_n        - asynchronous active-low reset
//          en           - scan enable; low parks the scanner in IDLE
//          linha        - row lines, active-low, asynchronous
//          coluna       - column drive, one-cold while scanning
//          tecla_cod    - key code (lin*N_COL + col) of current/last event
//          tecla_valida - 1-cycle pulse: press accepted or auto-repeat
//          tecla_solta  - 1-cycle pulse: release accepted
//          tecla_ativa  - level: stable state is a single key
//          multipla     - level: stable state is several keys
// Rev    : 1.0 - initial parametrised release
// ============================================================================
module teclado_scan
  import teclado_pkg::*;
#(
  parameter  int N_LIN         = 4,
  parameter  int N_COL         = 4,
  parameter  int SETTLE_CYC    = 8,
  parameter  int DEB_FRAMES    = 3,
  parameter  int REPEAT_FRAMES = 0,
  localparam int CW            = (clog2(N_LIN * N_COL) < 1) ? 1 : clog2(N_LIN * N_COL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_LIN-1:0] linha,
  output logic [N_COL-1:0] coluna,
  output logic [CW-1:0]    tecla_cod,
  output logic             tecla_valida,
  output logic             tecla_solta,
  output logic             tecla_ativa,
  output logic             multipla
);

  localparam int COLW = (clog2(N_COL) < 1) ? 1 : clog2(N_COL);
  localparam int SW   = (clog2(SETTLE_CYC) < 1) ? 1 : clog2(SETTLE_CYC);
  localparam int RW   = (clog2(REPEAT_FRAMES + 1) < 1) ? 1 : clog2(REPEAT_FRAMES + 1);
  localparam logic [3:0]      DEB_W    = 4'(DEB_FRAMES);
  localparam logic [SW-1:0]   SET_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [COLW-1:0] COL_LAST = COLW'(N_COL - 1);

  // --------------------------------------------------------------------------
  // Row synchroniser
  // --------------------------------------------------------------------------
  logic [N_LIN-1:0] linha_s;

  teclado_sync #(.W(N_LIN)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (linha),
    .sync_o  (linha_s)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [COLW-1:0]  col_q, col_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [N_COL-1:0] coluna_q, coluna_d;
  logic [1:0]       found_q, found_d;      // saturates at 2
  logic [CW-1:0]    first_q, first_d;
  res_e             prev_kind_q, prev_kind_d;
  logic [CW-1:0]    prev_code_q, prev_code_d;
  logic [3:0]       deb_q, deb_d;
  res_e             stab_kind_q, stab_kind_d;
  logic [CW-1:0]    stab_code_q, stab_code_d;
  logic [RW-1:0]    rep_q, rep_d;
  logic [CW-1:0]    cod_q, cod_d;
  logic             valida_q, valida_d;
  logic             solta_q, solta_d;

  // --------------------------------------------------------------------------
  // Per-column sample: number of low rows (capped at 2) and the lowest row.
  // --------------------------------------------------------------------------
  int            col_n;
  int            col_first;
  logic [CW-1:0] col_code;

  always_comb begin
    col_n     = 0;
    col_first = 0;
    for (int l = N_LIN - 1; l >= 0; l--) begin
      if (!linha_s[l]) begin
        col_first = l;
        if (col_n < 2) col_n = col_n + 1;
      end
    end
    col_code = CW'(col_first * N_COL + int'(col_q));
  end

  // --------------------------------------------------------------------------
  // Frame result seen at EVAL; code normalised to 0 unless a single key so
  // NONE/MULT compare equal regardless of which keys made them.
  // --------------------------------------------------------------------------
  res_e          res_kind;
  logic [CW-1:0] res_code;

  always_comb begin
    res_kind = RES_NONE;
    res_code = '0;
    if (found_q == 2'd1) begin
      res_kind = RES_KEY;
      res_code = first_q;
    end else if (found_q != 2'd0) begin
      res_kind = RES_MULT;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic [3:0] deb_nx;
  int         found_sum;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    settle_d    = settle_q;
    found_d     = found_q;
    first_d     = first_q;
    prev_kind_d = prev_kind_q;
    prev_code_d = prev_code_q;
    deb_d       = deb_q;
    stab_kind_d = stab_kind_q;
    stab_code_d = stab_code_q;
    rep_d       = rep_q;
    cod_d       = cod_q;
    valida_d    = 1'b0;
    solta_d     = 1'b0;
    deb_nx      = '0;
    found_sum   = 0;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d  = ST_DRIVE;
          col_d    = '0;
          settle_d = '0;
          found_d  = '0;
          first_d  = '0;
        end
      end

      ST_DRIVE: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (settle_q == SET_LAST) begin
          found_sum = int'(found_q) + col_n;
          found_d   = (found_sum >= 2) ? 2'd2 : 2'(found_sum);
          if (found_q == 2'd0 && col_n != 0) first_d = col_code;
          settle_d = '0;
          if (col_q == COL_LAST) state_d = ST_EVAL;
          else                   col_d   = col_q + 1'b1;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      ST_EVAL: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else begin
          if (res_kind == prev_kind_q && res_code == prev_code_q)
            deb_nx = (deb_q >= DEB_W) ? DEB_W : deb_q + 1'b1;
          else
            deb_nx = 4'd1;
          deb_d       = deb_nx;
          prev_kind_d = res_kind;
          prev_code_d = res_code;

          if (deb_nx == DEB_W && (res_kind != stab_kind_q || res_code != stab_code_q)) begin
            if (res_kind == RES_KEY) begin
              valida_d = 1'b1;
              cod_d    = res_code;
            end else if (res_kind == RES_NONE && stab_kind_q == RES_KEY) begin
              solta_d = 1'b1;
              cod_d   = stab_code_q;
            end
            stab_kind_d = res_kind;
            stab_code_d = res_code;
            rep_d       = '0;
          end else if (REPEAT_FRAMES > 0 && stab_kind_q == RES_KEY) begin
            if (int'(rep_q) >= REPEAT_FRAMES - 1) begin
              valida_d = 1'b1;
              cod_d    = stab_code_q;
              rep_d    = '0;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end

          state_d  = ST_DRIVE;
          col_d    = '0;
          settle_d = '0;
          found_d  = '0;
          first_d  = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Column drive is registered from the next state so it lines up with the
    // first cycle of each DRIVE column.
    coluna_d = '1;
    if (state_d == ST_DRIVE) coluna_d[col_d] = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      settle_q    <= '0;
      coluna_q    <= '1;
      found_q     <= '0;
      first_q     <= '0;
      prev_kind_q <= RES_NONE;
      prev_code_q <= '0;
      deb_q       <= '0;
      stab_kind_q <= RES_NONE;
      stab_code_q <= '0;
      rep_q       <= '0;
      cod_q       <= '0;
      valida_q    <= 1'b0;
      solta_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      settle_q    <= settle_d;
      coluna_q    <= coluna_d;
      found_q     <= found_d;
      first_q     <= first_d;
      prev_kind_q <= prev_kind_d;
      prev_code_q <= prev_code_d;
      deb_q       <= deb_d;
      stab_kind_q <= stab_kind_d;
      stab_code_q <= stab_code_d;
      rep_q       <= rep_d;
      cod_q       <= cod_d;
      valida_q    <= valida_d;
      solta_q     <= solta_d;
    end
  end

  assign coluna       = coluna_q;
  assign tecla_cod    = cod_q;
  assign tecla_valida = valida_q;
  assign tecla_solta  = solta_q;
  assign tecla_ativa  = (stab_kind_q == RES_KEY);
  assign multipla     = (stab_kind_q == RES_MULT);

endmodule
`default_nettype wire

// File: tb/tb_teclado_scan.sv
`default_nettype none
// ============================================================================
// Module : tb_teclado_scan
// Purpose: Self-checking bench for teclado_scan. Two instances run in lockstep
//          (no repeat / repeat every 8 frames) against a frame-level model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_teclado_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] pressed = '0;   // bit lin*4+col set = key held

  logic [3:0] linha_w [2];
  logic [3:0] coluna_w[2];
  logic [3:0] cod_w   [2];
  logic       val_w   [2];
  logic       sol_w   [2];
  logic       atv_w   [2];
  logic       mul_w   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Physical keypad: a row reads low when a held key joins it to a low column.
  function automatic logic [3:0] rows(input logic [15:0] keys, input logic [3:0] col);
    logic [3:0] r;
    for (int l = 0; l < 4; l++) r[l] = ~|(keys[l*4 +: 4] & ~col);
    return r;
  endfunction

  assign linha_w[0] = rows(pressed, coluna_w[0]);
  assign linha_w[1] = rows(pressed, coluna_w[1]);

  teclado_scan #(.N_LIN(4), .N_COL(4), .SETTLE_CYC(4), .DEB_FRAMES(3), .REPEAT_FRAMES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .linha(linha_w[0]), .coluna(coluna_w[0]),
    .tecla_cod(cod_w[0]), .tecla_valida(val_w[0]), .tecla_solta(sol_w[0]),
    .tecla_ativa(atv_w[0]), .multipla(mul_w[0]));

  teclado_scan #(.N_LIN(4), .N_COL(4), .SETTLE_CYC(4), .DEB_FRAMES(3), .REPEAT_FRAMES(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .linha(linha_w[1]), .coluna(coluna_w[1]),
    .tecla_cod(cod_w[1]), .tecla_valida(val_w[1]), .tecla_solta(sol_w[1]),
    .tecla_ativa(atv_w[1]), .multipla(mul_w[1]));

  // --------------------------------------------------------------------------
  // Frame-level reference model. Kinds: 0 none, 1 single key, 2 several.
  // --------------------------------------------------------------------------
  int rep_per[2] = '{0, 8};
  int m_prev_k[2], m_prev_c[2], m_deb[2], m_stab_k[2], m_stab_c[2];
  int m_rep[2], m_cod[2], m_pval[2], m_psol[2];
  int n_val[2], n_sol[2];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_prev_k[d] = 0; m_prev_c[d] = 0; m_deb[d] = 0;
      m_stab_k[d] = 0; m_stab_c[d] = 0; m_rep[d] = 0;
      m_cod[d] = 0; m_pval[d] = 0; m_psol[d] = 0;
    end
  endfunction

  function automatic void model_frame(input logic [15:0] keys);
    int n, rk, rc;
    n = $countones(keys);
    rk = (n == 0) ? 0 : (n == 1) ? 1 : 2;
    rc = 0;
    if (rk == 1) for (int k = 0; k < 16; k++) if (keys[k]) rc = k;
    for (int d = 0; d < 2; d++) begin
      if (rk == m_prev_k[d] && rc == m_prev_c[d]) m_deb[d] = (m_deb[d] < 3) ? m_deb[d] + 1 : 3;
      else m_deb[d] = 1;
      m_prev_k[d] = rk; m_prev_c[d] = rc;
      m_pval[d] = 0; m_psol[d] = 0;
      if (m_deb[d] == 3 && (rk != m_stab_k[d] || rc != m_stab_c[d])) begin
        if (rk == 1) begin m_pval[d] = 1; m_cod[d] = rc; end
        else if (rk == 0 && m_stab_k[d] == 1) begin m_psol[d] = 1; m_cod[d] = m_stab_c[d]; end
        m_stab_k[d] = rk; m_stab_c[d] = rc; m_rep[d] = 0;
      end else if (rep_per[d] > 0 && m_stab_k[d] == 1) begin
        m_rep[d]++;
        if (m_rep[d] == rep_per[d]) begin m_pval[d] = 1; m_cod[d] = m_stab_c[d]; m_rep[d] = 0; end
      end
    end
  endfunction

  // One full frame with a constant key set, starting just before column 0.
  task automatic run_frame(input logic [15:0] keys);
    logic [3:0] exp_col;
    pressed = keys;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      exp_col = (i <= 16) ? ~(4'b0001 << ((i - 1) / 4)) : 4'b1111;
      for (int d = 0; d < 2; d++) begin
        if (val_w[d]) n_val[d]++;
        if (sol_w[d]) n_sol[d]++;
        checks++;
        if (coluna_w[d] !== exp_col) begin
          errors++;
          $display("FAIL coluna dut%0d cyc%0d: got %b expected %b", d, i, coluna_w[d], exp_col);
        end
        checks++;
        if (val_w[d] !== ((i == 1) ? m_pval[d][0] : 1'b0)) begin
          errors++;
          $display("FAIL valida dut%0d cyc%0d: got %b expected %0d", d, i, val_w[d], (i == 1) ? m_pval[d] : 0);
        end
        checks++;
        if (sol_w[d] !== ((i == 1) ? m_psol[d][0] : 1'b0)) begin
          errors++;
          $display("FAIL solta dut%0d cyc%0d: got %b expected %0d", d, i, sol_w[d], (i == 1) ? m_psol[d] : 0);
        end
        if (i == 1) begin
          checks++;
          if (cod_w[d] !== 4'(m_cod[d])) begin
            errors++;
            $display("FAIL cod dut%0d: got %0d expected %0d", d, cod_w[d], m_cod[d]);
          end
          checks++;
          if (atv_w[d] !== (m_stab_k[d] == 1) || mul_w[d] !== (m_stab_k[d] == 2)) begin
            errors++;
            $display("FAIL levels dut%0d: got ativa=%b multipla=%b expected kind %0d", d, atv_w[d], mul_w[d], m_stab_k[d]);
          end
        end
      end
    end
    model_frame(keys);
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++) begin n_val[d] = 0; n_sol[d] = 0; end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (coluna_w[d] !== 4'b1111 || cod_w[d] !== 4'd0 || val_w[d] !== 1'b0 ||
          sol_w[d] !== 1'b0 || atv_w[d] !== 1'b0 || mul_w[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: got col=%b cod=%0d v=%b s=%b a=%b m=%b expected 1111/0/0/0/0/0",
                 d, coluna_w[d], cod_w[d], val_w[d], sol_w[d], atv_w[d], mul_w[d]);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (coluna_w[d] !== 4'b1111) begin
        errors++;
        $display("FAIL idle_col dut%0d: got %b expected 1111", d, coluna_w[d]);
      end
    end
    model_reset();
  endtask

  task automatic test_idle_scan();
    clear_counts();
    en = 1'b1;
    repeat (3) run_frame(16'h0000);
    checks++;
    if (n_val[0] + n_sol[0] + n_val[1] + n_sol[1] != 0) begin
      errors++;
      $display("FAIL idle_pulses: got %0d expected 0", n_val[0] + n_sol[0] + n_val[1] + n_sol[1]);
    end
  endtask

  task automatic test_key_press();
    clear_counts();
    repeat (10) run_frame(16'h0040);
    checks++;
    if (n_val[0] != 1) begin
      errors++;
      $display("FAIL press_count: got %0d expected 1", n_val[0]);
    end
    checks++;
    if (atv_w[0] !== 1'b1 || cod_w[0] !== 4'd6) begin
      errors++;
      $display("FAIL press_state: got ativa=%b cod=%0d expected 1/6", atv_w[0], cod_w[0]);
    end
  endtask

  task automatic test_bounce();
    clear_counts();
    for (int f = 0; f < 8; f++) run_frame((f % 2 == 0) ? 16'h0000 : 16'h0040);
    checks++;
    if (n_val[0] + n_sol[0] != 0) begin
      errors++;
      $display("FAIL bounce_pulses: got %0d expected 0", n_val[0] + n_sol[0]);
    end
    repeat (4) run_frame(16'h0000);
    checks++;
    if (n_sol[0] != 1 || n_val[0] != 0 || cod_w[0] !== 4'd6) begin
      errors++;
      $display("FAIL release: got solta=%0d valida=%0d cod=%0d expected 1/0/6", n_sol[0], n_val[0], cod_w[0]);
    end
  endtask

  task automatic test_multi();
    clear_counts();
    repeat (4) run_frame(16'h0021);
    checks++;
    if (mul_w[0] !== 1'b1 || atv_w[0] !== 1'b0 || n_val[0] + n_sol[0] != 0) begin
      errors++;
      $display("FAIL multi: got multipla=%b ativa=%b pulses=%0d expected 1/0/0", mul_w[0], atv_w[0], n_val[0] + n_sol[0]);
    end
    repeat (4) run_frame(16'h0001);
    checks++;
    if (n_val[0] != 1 || cod_w[0] !== 4'd0 || atv_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL multi_release: got valida=%0d cod=%0d ativa=%b expected 1/0/1", n_val[0], cod_w[0], atv_w[0]);
    end
    repeat (4) run_frame(16'h0000);
  endtask

  task automatic test_repeat();
    clear_counts();
    repeat (30) run_frame(16'h8000);
    checks++;
    if (n_val[1] != 4 || cod_w[1] !== 4'd15) begin
      errors++;
      $display("FAIL repeat: got pulses=%0d cod=%0d expected 4/15", n_val[1], cod_w[1]);
    end
    checks++;
    if (n_val[0] != 1) begin
      errors++;
      $display("FAIL no_repeat: got pulses=%0d expected 1", n_val[0]);
    end
    repeat (4) run_frame(16'h0000);
  endtask

  task automatic test_random();
    logic [15:0] keys;
    int sel, hold;
    for (int s = 0; s < 25; s++) begin
      sel = $urandom_range(0, 2);
      keys = '0;
      if (sel >= 1) keys[$urandom_range(0, 15)] = 1'b1;
      if (sel == 2) keys[$urandom_range(0, 15)] = 1'b1;
      hold = $urandom_range(1, 5);
      repeat (hold) run_frame(keys);
    end
    repeat (4) run_frame(16'h0000);
  endtask

  task automatic test_en_drop();
    repeat (5) run_frame(16'h0200);
    @(negedge clk);   // pulse slot of the last full frame
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (val_w[d] !== m_pval[d][0] || sol_w[d] !== m_psol[d][0]) begin
        errors++;
        $display("FAIL drop_slot dut%0d: got v=%b s=%b expected %0d/%0d", d, val_w[d], sol_w[d], m_pval[d], m_psol[d]);
      end
      m_pval[d] = 0; m_psol[d] = 0;
    end
    repeat (4) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (coluna_w[d] !== 4'b1111 || val_w[d] !== 1'b0 || sol_w[d] !== 1'b0 ||
            atv_w[d] !== 1'b1 || cod_w[d] !== 4'd9) begin
          errors++;
          $display("FAIL en_drop dut%0d cyc%0d: got col=%b v=%b s=%b a=%b cod=%0d expected 1111/0/0/1/9",
                   d, i, coluna_w[d], val_w[d], sol_w[d], atv_w[d], cod_w[d]);
        end
      end
    end
    en = 1'b1;
    repeat (3) run_frame(16'h0200);
  endtask

  task automatic test_rst_mid();
    repeat (4) run_frame(16'h0008);
    checks++;
    if (atv_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_ativa: got %b expected 1", atv_w[0]);
    end
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (coluna_w[d] !== 4'b1111 || cod_w[d] !== 4'd0 || val_w[d] !== 1'b0 ||
          sol_w[d] !== 1'b0 || atv_w[d] !== 1'b0 || mul_w[d] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset dut%0d: got col=%b cod=%0d v=%b s=%b a=%b m=%b expected 1111/0/0/0/0/0",
                 d, coluna_w[d], cod_w[d], val_w[d], sol_w[d], atv_w[d], mul_w[d]);
      end
    end
    model_reset();
    pressed = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) run_frame(16'h0000);
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_key_press();
    test_bounce();
    test_multi();
    test_repeat();
    test_random();
    test_en_drop();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
